dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bus bridge sitting directly downstream of the pipeline's ME stage. It converts the single-cycle ME-stage memory request into a handshake bus request with address and data phases, then returns load data. It holds the pipeline through a stall output until the transaction completes. It also keeps returned data stable while the pipeline is frozen for other reasons.

## Interface
Parameters:
- ADDR_W, 32, address width (data width is fixed at 32)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_en  in  1  ME-stage instruction is a load or store
- mem_wen  in  4  byte write enables; 0 means load
- mem_addr  in  ADDR_W  ME-stage ALU result address
- mem_wdata  in  32  store data, already lane-replicated
- cpu_stall  in  1  ME held by another hazard source
- mem_rdata  out  32  registered load word, unaligned word returned as-is
- mem_stall  out  1  freeze IF through ME
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  ADDR_W  bus address
- data_wdata  out  32  bus write data
- data_wstrb  out  4  bus byte strobes
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase done; rdata valid
- data_rdata  in  32  bus read data

## Operation
The state machine has four states: IDLE, REQ, WAIT and DONE.
- IDLE
  - If mem_en=1: latch addr, wdata and wstrb=mem_wen, then go to REQ.
  - Latched address: mem_addr for stores; for loads, {mem_addr[ADDR_W-1:2],2'b00}.
  - data_wr = |mem_wen.
  - data_size for stores: 1111 gives 2; 0011 or 1100 gives 1; one-hot gives 0. Loads always use 2.
- REQ
  - data_req=1.
  - addr_ok=1 and data_ok=0: go to WAIT.
  - addr_ok=1 and data_ok=1: capture rdata and go to DONE.
- WAIT
  - data_req=0.
  - data_ok=1: capture data_rdata into mem_rdata (stores capture too, value ignored), then go to DONE.
- DONE
  - mem_stall=0.
  - cpu_stall=1: stay in DONE, hold mem_rdata, issue no new request.
  - Otherwise go to IDLE.
- mem_stall = (IDLE & mem_en) | REQ | WAIT. It is combinational on mem_en.
- Once addr_ok has been seen, a transaction always completes. There is no abort path.
- data_ok arriving in IDLE or DONE is ignored. A protocol violation is flagged by an assertion in simulation only.

## Timing
- Reset (asynchronous) forces:
  - state IDLE
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0
  - mem_rdata=0, mem_stall=0
- Minimum latency, zero-wait slave:
  - cycle 0: IDLE with mem_en; stall high
  - cycle 1: REQ with addr_ok and data_ok; stall high
  - cycle 2: DONE; stall low, mem_rdata valid
  - Penalty is 2 cycles.
- While data_req=1, data_addr, data_wdata, data_wstrb, data_wr and data_size are stable until addr_ok.
- mem_rdata updates only on the capture edge and is held afterwards, including through IDLE.
- Back-to-back accesses: DONE, then IDLE, then the new request is seen in IDLE on the next cycle.
- Reset asserted in REQ or WAIT returns to IDLE immediately. The outstanding bus transaction is abandoned; the slave shares rst.

## Configuration
- DMEM_BRIDGE_VADDR_MAP_EN defined: latched addresses in 0x8000_0000 to 0xBFFF_FFFF (kseg0/kseg1) get bits [31:29] cleared. All other addresses pass through unchanged.
- DMEM_BRIDGE_VADDR_MAP_EN undefined: data_addr equals the latched address with no translation. The translation logic is not compiled in.

## Structure
- defines.vh holds:
  - state encodings: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3
  - size codes: SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2
- One sub-module, dmem_addr_map: combinational address translation, instantiated only under DMEM_BRIDGE_VADDR_MAP_EN.

## Test plan
- Load, zero-wait slave
  - Stimulus: mem_en=1, wen=0, addr=0x0000_0106; slave gives addr_ok=data_ok=1 in cycle 1 with rdata=0xDEADBEEF.
  - Response: cycle 1 shows data_req=1, data_addr=0x0000_0104, data_size=2, data_wr=0; cycle 2 shows mem_rdata=0xDEADBEEF, mem_stall=0.
- Store byte
  - Stimulus: wen=0100, addr=0x0000_0012, wdata=0x5A5A5A5A.
  - Response: data_wr=1, data_size=0, data_wstrb=0100, data_addr=0x0000_0012, data_wdata=0x5A5A5A5A.
- Delayed addr_ok
  - Stimulus: addr_ok held low 3 cycles, then data_ok 2 cycles later.
  - Response: request fields stable throughout; mem_stall high for 6 cycles; DONE in the cycle after data_ok.
- cpu_stall in DONE
  - Stimulus: cpu_stall=1 for 2 cycles while in DONE.
  - Response: state stays DONE, mem_rdata held, data_req=0; release moves to IDLE.
- Reset in WAIT
  - Stimulus: rst pulsed while in WAIT.
  - Response: data_req=0, mem_stall=0 and mem_rdata=0 immediately, without waiting for a clock edge.
- Address map
  - Stimulus: addr=0xBFC0_0010.
  - Response: data_addr=0x1FC0_0010 with DMEM_BRIDGE_VADDR_MAP_EN defined; 0xBFC0_0010 without it.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge.
//   - FSM state encoding (IDLE/REQ/WAIT/DONE)
//   - bus size codes (byte/half/word)
//   - packed request-attribute payload carried on the bus during a request
//   - helper deriving the bus size from the ME-stage byte write enables
package dmem_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Attributes latched at request time and held on the bus until accepted
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } req_attr_t;

    // Loads (wen==0) always move a full word; stores size from the strobe pattern
    function automatic logic [1:0] size_from_wen(input logic [STRB_W-1:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0000, 4'b1111: size = SIZE_WORD;
            4'b0011, 4'b1100: size = SIZE_HALF;
            default:          size = SIZE_BYTE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// Combinational kseg0/kseg1 virtual-to-physical translation.
// Compiled only when DMEM_BRIDGE_VADDR_MAP_EN is defined.
//   addr_i : latched request address
//   addr_o : translated address (top three bits cleared for 0x8000_0000..0xBFFF_FFFF)
`ifdef DMEM_BRIDGE_VADDR_MAP_EN
module dmem_addr_map #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Top two bits 2'b10 selects kseg0/kseg1; drop the segment bits
    always_comb begin
        addr_o = addr_i;
        if (addr_i[ADDR_W-1 -: 2] == 2'b10) begin
            addr_o[ADDR_W-1 -: 3] = 3'b000;
        end
    end

endmodule
`endif

// File: rtl/dmem_bridge.sv
// Data-memory bus bridge behind the ME stage: turns a single-cycle ME memory
// request into an address/data-phase handshake bus transaction, stalls the
// pipeline until it completes and holds returned load data.
// Optional feature: DMEM_BRIDGE_VADDR_MAP_EN enables kseg0/kseg1 translation.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_en/mem_wen/mem_addr/mem_wdata   ME-stage request
//   cpu_stall                ME held by another hazard (keeps DONE)
//   mem_rdata, mem_stall     registered load word, pipeline freeze
//   data_req/wr/size/addr/wdata/wstrb   bus request phase
//   data_addr_ok/data_data_ok/data_rdata bus responses
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [STRB_W-1:0] mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              cpu_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [STRB_W-1:0] data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    req_attr_t         attr_q, attr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_lat_c;
    logic [ADDR_W-1:0] addr_map_c;

    // Loads are issued word-aligned; stores keep the byte address
    assign addr_lat_c = (|mem_wen) ? mem_addr : {mem_addr[ADDR_W-1:2], 2'b00};

`ifdef DMEM_BRIDGE_VADDR_MAP_EN
    dmem_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
        .addr_i (addr_lat_c),
        .addr_o (addr_map_c)
    );
`else
    assign addr_map_c = addr_lat_c;
`endif

    // State and request/response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            attr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            attr_q  <= attr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        attr_d  = attr_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_en) begin
                    addr_d       = addr_map_c;
                    attr_d.wr    = |mem_wen;
                    attr_d.size  = size_from_wen(mem_wen);
                    attr_d.wstrb = mem_wen;
                    attr_d.wdata = mem_wdata;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        rdata_d = data_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Stores capture as well; the value is simply not consumed
                if (data_data_ok) begin
                    rdata_d = data_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cpu_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = attr_q.wr;
    assign data_size  = attr_q.size;
    assign data_addr  = addr_q;
    assign data_wdata = attr_q.wdata;
    assign data_wstrb = attr_q.wstrb;
    assign mem_rdata  = rdata_q;

    // Combinational on mem_en so the pipeline freezes in the request cycle;
    // reset masks it so the stall drops together with the async reset
    assign mem_stall = (state_q == ST_IDLE && mem_en && !rst)
                     || (state_q == ST_REQ)
                     || (state_q == ST_WAIT);

`ifndef SYNTHESIS
    // Slave must only return data for an accepted, outstanding request
    a_data_ok_when_pending: assert property (@(posedge clk) disable iff (rst)
        data_data_ok |-> (state_q == ST_REQ || state_q == ST_WAIT));
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed transactions against a
// per-cycle expectation model plus hand-computed literal checks.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic [3:0]  mem_wen = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        cpu_stall = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;

    dmem_bridge #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_stall    (cpu_stall),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    // Model state: what the outputs must be in the current cycle
    logic        chk_on = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_stall = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_wr = 1'b0;
    logic [1:0]  exp_size = '0;
    logic [3:0]  exp_wstrb = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] wen);
        logic [31:0] r;
        r = (wen != 4'h0) ? a : (a & 32'hFFFF_FFFC);
`ifdef DMEM_BRIDGE_VADDR_MAP_EN
        if (r >= 32'h8000_0000 && r <= 32'hBFFF_FFFF) r = r & 32'h1FFF_FFFF;
`endif
        return r;
    endfunction

    function automatic logic [1:0] model_size(input logic [3:0] wen);
        if (wen == 4'h0 || wen == 4'hF) return 2'd2;
        if (wen == 4'h3 || wen == 4'hC) return 2'd1;
        return 2'd0;
    endfunction

    // Single compare process, sampled on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("data_req", 32'(data_req), 32'(exp_req));
            chk("mem_rdata", mem_rdata, exp_rdata);
            if (exp_req) begin
                chk("data_addr", data_addr, exp_addr);
                chk("data_wr", 32'(data_wr), 32'(exp_wr));
                chk("data_size", 32'(data_size), 32'(exp_size));
                chk("data_wstrb", 32'(data_wstrb), 32'(exp_wstrb));
                chk("data_wdata", data_wdata, exp_wdata);
            end
        end
        if (mem_stall) stall_cycles++;
    end

    // One transaction: a_dly cycles before addr_ok, data_ok d_dly cycles after
    // acceptance (0 = same cycle), then DONE held for 'hold' extra cycles.
    // Returns in the last DONE cycle.
    task automatic do_txn(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input int a_dly, input int d_dly,
                          input logic [31:0] rdata, input int hold);
        @(posedge clk); #1;
        mem_en    = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        exp_addr  = model_addr(addr, wen);
        exp_wr    = (wen != 4'h0);
        exp_size  = model_size(wen);
        exp_wstrb = wen;
        exp_wdata = wdata;
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        for (int k = 0; k <= a_dly; k++) begin
            @(posedge clk); #1;
            exp_req      = 1'b1;
            data_addr_ok = (k == a_dly);
            data_data_ok = (k == a_dly) && (d_dly == 0);
            data_rdata   = data_data_ok ? rdata : ~rdata;
        end
        for (int j = 1; j <= d_dly; j++) begin
            @(posedge clk); #1;
            exp_req      = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = (j == d_dly);
            data_rdata   = data_data_ok ? rdata : ~rdata;
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0BAD_0BAD;
        mem_en       = 1'b0;
        exp_rdata    = rdata;
        exp_stall    = 1'b0;
        exp_req      = 1'b0;
        cpu_stall    = (hold > 0);
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            cpu_stall = (h < hold);
        end
    endtask

    int s0;

    initial begin
        // Reset values while reset is asserted
        #1;
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_mem_stall", 32'(mem_stall), 32'h0);
        chk("rst_data_req", 32'(data_req), 32'h0);
        chk("rst_data_wr", 32'(data_wr), 32'h0);
        chk("rst_data_size", 32'(data_size), 32'h0);
        chk("rst_data_addr", data_addr, 32'h0);
        chk("rst_data_wdata", data_wdata, 32'h0);
        chk("rst_data_wstrb", 32'(data_wstrb), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;

        // Load, zero-wait slave
        s0 = stall_cycles;
        do_txn(4'h0, 32'h0000_0106, 32'h1111_2222, 0, 0, 32'hDEADBEEF, 0);
        chk("load_rdata", mem_rdata, 32'hDEADBEEF);
        chk("load_addr", data_addr, 32'h0000_0104);
        chk("load_size", 32'(data_size), 32'd2);
        chk("load_wr", 32'(data_wr), 32'd0);
        chk("load_penalty", 32'(stall_cycles - s0), 32'd2);

        // Store byte, back-to-back, with cpu_stall held 2 cycles in DONE
        do_txn(4'b0100, 32'h0000_0012, 32'h5A5A_5A5A, 0, 0, 32'h1234_5678, 2);
        chk("sb_wr", 32'(data_wr), 32'd1);
        chk("sb_size", 32'(data_size), 32'd0);
        chk("sb_wstrb", 32'(data_wstrb), 32'b0100);
        chk("sb_addr", data_addr, 32'h0000_0012);
        chk("sb_wdata", data_wdata, 32'h5A5A_5A5A);
        chk("sb_rdata_held", mem_rdata, 32'h1234_5678);

        // Delayed addr_ok (3 cycles low) then data_ok in the following WAIT cycle
        s0 = stall_cycles;
        do_txn(4'h0, 32'h2000_0203, 32'h0, 3, 1, 32'hCAFE_F00D, 0);
        chk("dly_stall_cycles", 32'(stall_cycles - s0), 32'd6);
        chk("dly_rdata", mem_rdata, 32'hCAFE_F00D);
        chk("dly_addr", data_addr, 32'h2000_0200);

        // Halfword stores and a word store across the kseg boundary
        do_txn(4'b1100, 32'h0000_4002, 32'hABCD_ABCD, 1, 2, 32'h0000_0001, 1);
        chk("sh_size", 32'(data_size), 32'd1);
        do_txn(4'b0011, 32'hC000_0000, 32'h0000_BEEF, 0, 1, 32'h0000_0002, 0);
        chk("sh_lo_size", 32'(data_size), 32'd1);
        chk("sh_lo_addr", data_addr, 32'hC000_0000);
        do_txn(4'b1111, 32'hBFC0_0010, 32'h7777_8888, 2, 0, 32'h0000_0003, 0);
`ifdef DMEM_BRIDGE_VADDR_MAP_EN
        chk("map_addr", data_addr, 32'h1FC0_0010);
`else
        chk("map_addr", data_addr, 32'hBFC0_0010);
`endif
        chk("sw_size", 32'(data_size), 32'd2);
        do_txn(4'h0, 32'h8000_0001, 32'h0, 0, 0, 32'h9999_0000, 0);

        // Reset asserted mid-cycle while in WAIT
        @(posedge clk); #1;
        mem_en    = 1'b1;
        mem_wen   = 4'h0;
        mem_addr  = 32'h0000_0040;
        mem_wdata = 32'h0;
        exp_addr  = model_addr(32'h0000_0040, 4'h0);
        exp_wr    = 1'b0;
        exp_size  = 2'd2;
        exp_wstrb = 4'h0;
        exp_wdata = 32'h0;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req      = 1'b1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        exp_req      = 1'b0;
        #2;
        exp_stall = 1'b0;
        exp_rdata = 32'h0;
        rst       = 1'b1;
        #1;
        chk("rstw_data_req", 32'(data_req), 32'h0);
        chk("rstw_mem_stall", 32'(mem_stall), 32'h0);
        chk("rstw_mem_rdata", mem_rdata, 32'h0);
        chk("rstw_data_addr", data_addr, 32'h0);
        mem_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Fresh transaction after the abandoned one
        do_txn(4'h0, 32'h0000_0080, 32'h0, 1, 0, 32'h4242_4242, 0);
        chk("post_rst_rdata", mem_rdata, 32'h4242_4242);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
